// File: rtl/lifo_stack_core.sv
// LIFO stack between the debounced push path and the pop pacing counter; pops land on a registered data_out one cycle later.
// No backpressure: rejected operations raise single-cycle overflow/underflow pulses instead of stalling.
module lifo_stack_core #(
  parameter  int DATA_WIDTH  = 4,
  parameter  int STACK_DEPTH = 16,
  localparam int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_edge,
  input  logic                  push_edge,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  citaj,
  input  logic                  citajVise,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = $clog2(STACK_DEPTH);

  logic [DATA_WIDTH-1:0] mem [STACK_DEPTH];

  logic          pop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;
  logic [CNT_W-1:0] count_nxt;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          do_pop;
  logic          ovf_nxt;
  logic          unf_nxt;

  assign pop         = citaj | citajVise;
  assign wr_idx      = AW'(count);
  assign top_idx     = AW'(count - CNT_W'(1));
  assign stack_empty = (count == '0);
  assign stack_full  = (count == CNT_W'(STACK_DEPTH));
  assign top_data    = stack_empty ? '0 : mem[top_idx];

  always_comb begin
    count_nxt = count;
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    do_pop    = 1'b0;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    case ({push_edge, pop})
      2'b10: begin
        if (stack_full) begin
          ovf_nxt = 1'b1;
        end else begin
          mem_we    = 1'b1;
          count_nxt = count + CNT_W'(1);
        end
      end
      2'b01: begin
        if (stack_empty) begin
          unf_nxt = 1'b1;
        end else begin
          do_pop    = 1'b1;
          count_nxt = count - CNT_W'(1);
        end
      end
      2'b11: begin
        // Replace-top keeps count, so a full stack never overflows here;
        // on an empty stack the pop half is rejected and the push proceeds.
        if (stack_empty) begin
          mem_we    = 1'b1;
          count_nxt = CNT_W'(1);
          unf_nxt   = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = top_idx;
          do_pop    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      count     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      out_valid <= do_pop;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
      if (do_pop) begin
        data_out <= mem[top_idx];
      end
    end
  end

endmodule

// File: tb/tb_lifo_stack_core.sv
// Bench for lifo_stack_core: directed scenarios plus random traffic, scored against a queue-based stack model.
module tb_lifo_stack_core;

  localparam int DW = 4;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_edge;
  logic          push_edge;
  logic [DW-1:0] data_in;
  logic          citaj;
  logic          citajVise;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic [DW-1:0] top_data;
  logic          stack_empty;
  logic          stack_full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  lifo_stack_core #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_edge(rst_edge), .push_edge(push_edge), .data_in(data_in),
    .citaj(citaj), .citajVise(citajVise), .data_out(data_out), .out_valid(out_valid),
    .top_data(top_data), .stack_empty(stack_empty), .stack_full(stack_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vld;
    int dout;
    int cnt;
    int top;
    int empty;
    int full;
    int ovf;
    int unf;
  } exp_t;

  exp_t exp_q[$];
  int   model_stk[$];
  int   model_dout;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Model: a plain queue used as a stack; back of the queue is the top.
  task automatic step(input bit p, input int d, input bit c, input bit v);
    exp_t e;
    bit   pp;
    @(negedge clk);
    push_edge = p;
    data_in   = DW'(d);
    citaj     = c;
    citajVise = v;
    pp = c | v;
    e.vld = 0; e.ovf = 0; e.unf = 0;
    if (p && !pp) begin
      if (model_stk.size() < DEPTH) model_stk.push_back(d % 16);
      else e.ovf = 1;
    end else if (pp && !p) begin
      if (model_stk.size() > 0) begin
        model_dout = model_stk.pop_back();
        e.vld = 1;
      end else e.unf = 1;
    end else if (pp && p) begin
      if (model_stk.size() > 0) begin
        model_dout = model_stk[$];
        model_stk[$] = d % 16;
        e.vld = 1;
      end else begin
        model_stk.push_back(d % 16);
        e.unf = 1;
      end
    end
    e.dout  = model_dout;
    e.cnt   = model_stk.size();
    e.top   = (model_stk.size() > 0) ? model_stk[$] : 0;
    e.empty = (model_stk.size() == 0) ? 1 : 0;
    e.full  = (model_stk.size() == DEPTH) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    push_edge = 1'b0;
    citaj     = 1'b0;
    citajVise = 1'b0;
    data_in   = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(stack_empty), 1);
    chk({tag, "_full"}, int'(stack_full), 0);
    chk({tag, "_data_out"}, int'(data_out), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_underflow"}, int'(underflow), 0);
  endtask

  initial begin : monitor
    exp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("out_valid", int'(out_valid), r.vld);
        chk("data_out", int'(data_out), r.dout);
        chk("count", int'(count), r.cnt);
        chk("top_data", int'(top_data), r.top);
        chk("stack_empty", int'(stack_empty), r.empty);
        chk("stack_full", int'(stack_full), r.full);
        chk("overflow", int'(overflow), r.ovf);
        chk("underflow", int'(underflow), r.unf);
      end else if (out_valid) begin
        chk("unexpected_out_valid", int'(out_valid), 0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    int pp;
    int pc;
    rst_edge = 1'b1;
    idle_inputs();
    model_dout = 0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst_edge = 1'b0;

    // Basic push/pop ordering
    step(1, 3, 0, 0);
    step(1, 7, 0, 0);
    step(1, 9, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Fill, overflow, replace-top while full, then drain
    for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0);
    step(1, 5, 0, 0);
    step(0, 0, 0, 0);
    step(1, 9, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, i % 2 == 0, i % 2 == 1);

    // Underflow must leave data_out holding the last popped word
    step(1, 11, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);

    // Replace-top, dual strobe single pop, push+pop on empty
    step(1, 4, 0, 0);
    step(1, 6, 0, 0);
    step(1, 2, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(1, 13, 0, 1);
    step(0, 0, 0, 0);

    // Asynchronous reset between clock edges
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(0, 0, 1, 0);
    @(negedge clk);
    idle_inputs();
    #2;
    rst_edge = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_edge = 1'b0;
    model_stk.delete();
    model_dout = 0;

    // Random traffic alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 800; i++) begin
      if ((i / 100) % 2 == 0) begin pp = 70; pc = 25; end
      else begin pp = 20; pc = 60; end
      step($urandom_range(0, 99) < pp, int'($urandom_range(0, 15)),
           $urandom_range(0, 99) < pc, $urandom_range(0, 99) < pc / 2);
    end
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) chk("scoreboard_drain", exp_q.size(), 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lifo_stack_core.md
Name: lifo_stack_core

Overview:
- Parameterised LIFO storage stage directly downstream of the pop/read-more pacing counter.
- Accepts pushes from the debounced push button path.
- Consumes the single-cycle read strobes `citaj` (manual pop) and `citajVise` (timed repeated pop).
- Presents the popped word on a registered output for the display stage.
- Exposes the current top-of-stack word and `stack_empty` back to the pacing counter.

Parameters:
- DATA_WIDTH, 4, width of each stored word.
- STACK_DEPTH, 16, number of entries. Must be at least 2.
- CNT_W, $clog2(STACK_DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_edge  in  1  asynchronous, active-high reset.
- push_edge  in  1  single-cycle push strobe.
- data_in  in  DATA_WIDTH  word written on push.
- citaj  in  1  single-cycle pop strobe (manual).
- citajVise  in  1  single-cycle pop strobe (timed repeat).
- data_out  out  DATA_WIDTH  last popped word, registered.
- out_valid  out  1  one-cycle pulse when data_out is updated.
- top_data  out  DATA_WIDTH  current top entry; combinational from the memory; 0 when empty.
- stack_empty  out  1  high when count == 0.
- stack_full  out  1  high when count == STACK_DEPTH.
- count  out  CNT_W  number of valid entries.
- overflow  out  1  one-cycle pulse: push rejected because the stack is full.
- underflow  out  1  one-cycle pulse: pop rejected because the stack is empty.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - count = 0, data_out = 0, out_valid = 0, overflow = 0, underflow = 0.
  - stack_empty = 1, stack_full = 0.
  - Memory contents are not cleared and are don't-care.
- Pop request: pop = citaj | citajVise. Both strobes high in the same cycle count as one pop.
- Storage and pointer:
  - Storage is array mem[0..STACK_DEPTH-1].
  - The write pointer equals count; the top entry is mem[count-1].
- Operation select, evaluated per clock from (push_edge, pop, count):
  - IDLE (no push, no pop):
    - No state change.
    - out_valid = 0, overflow = 0, underflow = 0.
  - PUSH only, count < STACK_DEPTH:
    - mem[count] <= data_in, count <= count+1.
  - PUSH only, full:
    - Push is ignored; memory and count are unchanged.
    - overflow = 1 for one cycle.
  - POP only, count > 0:
    - data_out <= mem[count-1], count <= count-1, out_valid = 1 for one cycle.
  - POP only, empty:
    - data_out holds its value, count stays 0.
    - underflow = 1 for one cycle, out_valid = 0.
  - PUSH+POP, count > 0 (replace-top):
    - data_out <= old mem[count-1], out_valid = 1.
    - mem[count-1] <= data_in, count is unchanged.
    - Applies when full too; no overflow is flagged.
  - PUSH+POP, empty:
    - Treated as PUSH only: mem[0] <= data_in, count <= 1.
    - underflow = 1 for one cycle, out_valid = 0.
- Latency:
  - data_out and out_valid are valid in the cycle after the strobe.
  - count, stack_empty, stack_full and top_data reflect the new state in that same following cycle.
- Flag derivation:
  - stack_empty and stack_full are decoded from the count register, so they are glitch-free.
  - stack_empty must be valid in the cycle following each pop, so the pacing counter can abort its repeat sequence on empty.
- Arithmetic: count never wraps. Increment is blocked at STACK_DEPTH; decrement is blocked at 0.
- top_data:
  - Equals mem[count-1] when count > 0, else 0.
  - The pacing counter samples it as its repetition count.
- Strobe inputs:
  - All strobes are assumed to be single-cycle pulses from upstream edge detectors.
  - A held-high strobe performs one operation per clock; no internal edge detection.
- Single-cycle pulses: overflow, underflow and out_valid are single-cycle pulses and are never sticky.

Test Plan:
- Reset, then push 3, 7, 9 on separate cycles -> count=3, top_data=9, stack_empty=0, stack_full=0.
- Continuing, citaj three times -> data_out sequence 9, 7, 3, with out_valid pulsing each time; then count=0, stack_empty=1, top_data=0.
- Push 16 words 0..15 (wrapping in 4 bits), then push 5 -> stack_full=1 and overflow pulses once; count=16; top_data=15; mem unchanged.
- Empty stack: citajVise -> underflow pulse, data_out keeps its previous value, out_valid=0, count=0.
- Stack holding 4, 6: push_edge with data_in=2 plus citaj in the same cycle -> data_out=6, count=2, top_data=2. Then citaj and citajVise together -> a single pop, data_out=2, count=1.
- Push 1, 2, 3, then assert rst_edge asynchronously between clock edges -> count=0, stack_empty=1, data_out=0 immediately, without waiting for clk.
